// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - multi-lane branch resolution with redirect, link writeback and predictor-update queue
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               per-lane valid, unit ready (all lanes accepted together)
//   pc, inst, reg1, reg2            per-lane PC, instruction word, source operands
//   br_op                           per-lane branch opcode (0 none, 1..9 branch kinds)
//   pre_taken, pre_addr             per-lane front-end prediction
//   flush_in                        backend flush, blocks acceptance
//   res_valid, res_data             registered link-value writeback (BL/JIRL)
//   redirect, redirect_pc           registered front-end redirect
//   upd_valid/upd_ready, upd_pc, upd_target, upd_taken   predictor-update stream (queue head)
module branch_resolve_unit #(
  parameter int CHANNELS = 2,
  parameter int UQ_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHANNELS-1:0]      in_valid,
  output logic                     in_ready,
  input  logic [CHANNELS-1:0][31:0] pc,
  input  logic [CHANNELS-1:0][31:0] inst,
  input  logic [CHANNELS-1:0][31:0] reg1,
  input  logic [CHANNELS-1:0][31:0] reg2,
  input  logic [CHANNELS-1:0][3:0]  br_op,
  input  logic [CHANNELS-1:0]      pre_taken,
  input  logic [CHANNELS-1:0][31:0] pre_addr,
  input  logic                     flush_in,
  output logic [CHANNELS-1:0]      res_valid,
  output logic [CHANNELS-1:0][31:0] res_data,
  output logic                     redirect,
  output logic [31:0]              redirect_pc,
  output logic                     upd_valid,
  input  logic                     upd_ready,
  output logic [31:0]              upd_pc,
  output logic [31:0]              upd_target,
  output logic                     upd_taken
);

  localparam int PTR_W = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(UQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(UQ_DEPTH);
  localparam logic [CNT_W-1:0] CHAN_C  = CNT_W'(CHANNELS);

  localparam logic [3:0] OP_BEQ  = 4'd1;
  localparam logic [3:0] OP_BNE  = 4'd2;
  localparam logic [3:0] OP_BLT  = 4'd3;
  localparam logic [3:0] OP_BGE  = 4'd4;
  localparam logic [3:0] OP_BLTU = 4'd5;
  localparam logic [3:0] OP_BGEU = 4'd6;
  localparam logic [3:0] OP_B    = 4'd7;
  localparam logic [3:0] OP_BL   = 4'd8;
  localparam logic [3:0] OP_JIRL = 4'd9;

  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_q_pc     [UQ_DEPTH];
  logic [31:0]      r_q_target [UQ_DEPTH];
  logic             r_q_taken  [UQ_DEPTH];

  logic                      r_redirect;
  logic [31:0]               r_redirect_pc;
  logic [CHANNELS-1:0]       r_res_valid;
  logic [CHANNELS-1:0][31:0] r_res_data;

  logic [CHANNELS-1:0]       w_is_br, w_taken, w_mis, w_live, w_link, w_push;
  logic [CHANNELS-1:0][31:0] w_target, w_npc, w_off16, w_off26;
  logic [CHANNELS-1:0][PTR_W-1:0] w_push_off;
  logic [CNT_W-1:0]          w_push_cnt;
  logic [31:0]               w_redir_pc;
  logic                      w_any_mis, w_accept, w_pop;
  logic [CNT_W-1:0]          w_free;
  logic [25:0]               w_imm26;

  assign w_free    = DEPTH_C - r_count;
  // Cycle after a redirect the frontend is still delivering wrong-path lanes.
  assign in_ready  = (w_free >= CHAN_C) && !r_redirect;
  assign w_accept  = in_ready && !flush_in;
  assign upd_valid = (r_count != '0);
  assign w_pop     = upd_valid && upd_ready;

  // Per-lane decode, compare and target computation.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_imm26     = {inst[i][9:0], inst[i][25:10]};
      w_off16[i]  = {{14{inst[i][25]}}, inst[i][25:10], 2'b00};
      w_off26[i]  = {{4{w_imm26[25]}}, w_imm26, 2'b00};
      w_is_br[i]  = (br_op[i] >= OP_BEQ) && (br_op[i] <= OP_JIRL);
      w_link[i]   = (br_op[i] == OP_BL) || (br_op[i] == OP_JIRL);
      case (br_op[i])
        OP_BEQ:  w_taken[i] = (reg1[i] == reg2[i]);
        OP_BNE:  w_taken[i] = (reg1[i] != reg2[i]);
        OP_BLT:  w_taken[i] = ($signed(reg1[i]) <  $signed(reg2[i]));
        OP_BGE:  w_taken[i] = ($signed(reg1[i]) >= $signed(reg2[i]));
        OP_BLTU: w_taken[i] = (reg1[i] <  reg2[i]);
        OP_BGEU: w_taken[i] = (reg1[i] >= reg2[i]);
        OP_B, OP_BL, OP_JIRL: w_taken[i] = 1'b1;
        default: w_taken[i] = 1'b0;
      endcase
      if (br_op[i] == OP_JIRL)
        w_target[i] = reg1[i] + w_off16[i];
      else if ((br_op[i] == OP_B) || (br_op[i] == OP_BL))
        w_target[i] = pc[i] + w_off26[i];
      else
        w_target[i] = pc[i] + w_off16[i];
      w_npc[i] = w_taken[i] ? w_target[i] : (pc[i] + 32'd4);
      w_mis[i] = in_valid[i] && w_is_br[i] &&
                 ((w_taken[i] != pre_taken[i]) ||
                  (w_taken[i] && pre_taken[i] && (pre_addr[i] != w_target[i])));
    end
  end

  // Oldest mispredicting lane wins; everything younger is squashed.
  always_comb begin
    w_any_mis  = 1'b0;
    w_redir_pc = '0;
    w_push_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_live[i] = in_valid[i] && !w_any_mis;
      if (!w_any_mis && w_mis[i])
        w_redir_pc = w_npc[i];
      w_any_mis = w_any_mis || w_mis[i];
      w_push[i] = w_accept && w_live[i] && w_is_br[i];
      // Slot offset of this lane among this cycle's pushes keeps lane order.
      w_push_off[i] = w_push_cnt[PTR_W-1:0];
      if (w_push[i])
        w_push_cnt = w_push_cnt + ONE_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_res_valid   <= '0;
      r_res_data    <= '0;
    end else begin
      r_wptr     <= r_wptr + w_push_cnt[PTR_W-1:0];
      r_rptr     <= r_rptr + PTR_W'(w_pop);
      r_count    <= r_count + w_push_cnt - CNT_W'(w_pop);
      r_redirect <= w_accept && w_any_mis;
      if (w_accept && w_any_mis)
        r_redirect_pc <= w_redir_pc;
      for (int i = 0; i < CHANNELS; i++) begin
        r_res_valid[i] <= w_accept && w_live[i] && w_link[i];
        r_res_data[i]  <= (w_accept && w_live[i] && w_link[i]) ? (pc[i] + 32'd4) : 32'd0;
      end
    end
  end

  // Queue storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_push[i]) begin
        r_q_pc[r_wptr + w_push_off[i]]     <= pc[i];
        r_q_target[r_wptr + w_push_off[i]] <= w_npc[i];
        r_q_taken[r_wptr + w_push_off[i]]  <= w_taken[i];
      end
    end
  end

  assign upd_pc      = r_q_pc[r_rptr];
  assign upd_target  = r_q_target[r_rptr];
  assign upd_taken   = r_q_taken[r_rptr];
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       in_valid;
  logic             in_ready;
  logic [1:0][31:0] pc, inst, reg1, reg2, pre_addr;
  logic [1:0][3:0]  br_op;
  logic [1:0]       pre_taken;
  logic             flush_in;
  logic [1:0]       res_valid;
  logic [1:0][31:0] res_data;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             upd_valid, upd_ready, upd_taken;
  logic [31:0]      upd_pc, upd_target;

  int n_chk  = 0;
  int n_pass = 0;

  branch_resolve_unit #(.CHANNELS(2), .UQ_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .inst(inst), .reg1(reg1), .reg2(reg2), .br_op(br_op),
    .pre_taken(pre_taken), .pre_addr(pre_addr), .flush_in(flush_in),
    .res_valid(res_valid), .res_data(res_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc16(input logic [15:0] o);
    return {6'b0, o, 10'b0};
  endfunction

  function automatic logic [31:0] enc26(input logic [25:0] o);
    return {6'b0, o[15:0], o[25:16]};
  endfunction

  task automatic set_lane(input int i, input logic [3:0] op, input logic [31:0] p,
                          input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                          input logic pt, input logic [31:0] pa);
    in_valid[i] = 1'b1; br_op[i] = op; pc[i] = p; inst[i] = ins;
    reg1[i] = r1; reg2[i] = r2; pre_taken[i] = pt; pre_addr[i] = pa;
  endtask

  // Present the lanes for one edge; returns at the following negedge.
  task automatic issue();
    @(negedge clk);
    in_valid = '0;
    flush_in = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] ep, input logic [31:0] et, input logic ek);
    upd_ready = 1'b1;
    chk({tag, ".valid"},  {31'b0, upd_valid}, 32'd1);
    chk({tag, ".pc"},     upd_pc, ep);
    chk({tag, ".target"}, upd_target, et);
    chk({tag, ".taken"},  {31'b0, upd_taken}, {31'b0, ek});
    @(negedge clk);
    upd_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; flush_in = 1'b0; upd_ready = 1'b0;
    pc = '0; inst = '0; reg1 = '0; reg2 = '0; pre_addr = '0; br_op = '0; pre_taken = '0;
    repeat (2) @(negedge clk);
    chk("rst.redirect",  {31'b0, redirect}, 32'd0);
    chk("rst.res_valid", {30'b0, res_valid}, 32'd0);
    chk("rst.upd_valid", {31'b0, upd_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);

    // Correctly predicted taken BEQ.
    set_lane(0, 4'd1, 32'h1C000000, enc16(16'd4), 32'd5, 32'd5, 1'b1, 32'h1C000010);
    issue();
    chk("beq.redirect", {31'b0, redirect}, 32'd0);
    chk("beq.res_valid", {30'b0, res_valid}, 32'd0);
    pop_chk("beq.upd", 32'h1C000000, 32'h1C000010, 1'b1);
    chk("beq.empty", {31'b0, upd_valid}, 32'd0);

    // Signed BLT mispredicted not-taken; younger BL squashed.
    set_lane(0, 4'd3, 32'h1000, enc16(16'd8), 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0);
    set_lane(1, 4'd8, 32'h1004, enc26(26'd1), 32'd0, 32'd0, 1'b1, 32'h1008);
    issue();
    chk("blt.redirect",    {31'b0, redirect}, 32'd1);
    chk("blt.redirect_pc", redirect_pc, 32'h1020);
    chk("blt.res_valid",   {30'b0, res_valid}, 32'd0);
    chk("blt.in_ready",    {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("blt.redirect_1cyc", {31'b0, redirect}, 32'd0);
    chk("blt.in_ready_back", {31'b0, in_ready}, 32'd1);
    pop_chk("blt.upd", 32'h1000, 32'h1020, 1'b1);
    chk("blt.one_push", {31'b0, upd_valid}, 32'd0);

    // BNE not taken, predicted taken.
    set_lane(0, 4'd2, 32'h100, enc16(16'd4), 32'd1, 32'd1, 1'b1, 32'h110);
    issue();
    chk("bne.redirect",    {31'b0, redirect}, 32'd1);
    chk("bne.redirect_pc", redirect_pc, 32'h104);
    @(negedge clk);
    pop_chk("bne.upd", 32'h100, 32'h104, 1'b0);

    // BLTU 0xFFFFFFFF < 1 is false.
    set_lane(0, 4'd5, 32'h200, enc16(16'd4), 32'hFFFFFFFF, 32'd1, 1'b1, 32'h210);
    issue();
    chk("bltu.redirect",    {31'b0, redirect}, 32'd1);
    chk("bltu.redirect_pc", redirect_pc, 32'h204);
    @(negedge clk);
    pop_chk("bltu.upd", 32'h200, 32'h204, 1'b0);

    // JIRL with negative offset plus BL, both predicted correctly.
    set_lane(0, 4'd9, 32'h300, enc16(16'hFFFF), 32'h2000, 32'd0, 1'b1, 32'h1FFC);
    set_lane(1, 4'd8, 32'h304, enc26(26'd2), 32'd0, 32'd0, 1'b1, 32'h30C);
    issue();
    chk("jirl.redirect",   {31'b0, redirect}, 32'd0);
    chk("jirl.res_valid",  {30'b0, res_valid}, 32'd3);
    chk("jirl.res_data0",  res_data[0], 32'h304);
    chk("jirl.res_data1",  res_data[1], 32'h308);
    pop_chk("jirl.upd0", 32'h300, 32'h1FFC, 1'b1);
    chk("jirl.res_1cyc", {30'b0, res_valid}, 32'd0);
    pop_chk("jirl.upd1", 32'h304, 32'h30C, 1'b1);

    // Flush blocks acceptance entirely.
    set_lane(0, 4'd8, 32'h400, enc26(26'd4), 32'd0, 32'd0, 1'b0, 32'h0);
    flush_in = 1'b1;
    issue();
    chk("flush.redirect",  {31'b0, redirect}, 32'd0);
    chk("flush.res_valid", {30'b0, res_valid}, 32'd0);
    chk("flush.upd_valid", {31'b0, upd_valid}, 32'd0);

    // Fill to capacity with the consumer stalled.
    set_lane(0, 4'd1, 32'h10, enc16(16'd4), 32'd1, 32'd2, 1'b0, 32'h0);
    set_lane(1, 4'd4, 32'h14, enc16(16'd2), 32'd5, 32'd5, 1'b1, 32'h1C);
    issue();
    set_lane(0, 4'd7, 32'h20, enc26(26'h3FFFFF8), 32'd0, 32'd0, 1'b1, 32'h0);
    set_lane(1, 4'd6, 32'h24, enc16(16'd4), 32'd1, 32'd2, 1'b0, 32'h0);
    issue();
    chk("full.in_ready", {31'b0, in_ready}, 32'd0);
    chk("full.redirect", {31'b0, redirect}, 32'd0);
    pop_chk("full.a", 32'h10, 32'h14, 1'b0);
    chk("full.in_ready_1free", {31'b0, in_ready}, 32'd0);
    pop_chk("full.b", 32'h14, 32'h1C, 1'b1);
    chk("full.in_ready_2free", {31'b0, in_ready}, 32'd1);
    // Simultaneous push of two and pop of one, wrapping the write pointer.
    set_lane(0, 4'd5, 32'h40, enc16(16'd4), 32'd1, 32'd2, 1'b1, 32'h50);
    set_lane(1, 4'd8, 32'h44, enc26(26'd1), 32'd0, 32'd0, 1'b1, 32'h48);
    upd_ready = 1'b1;
    chk("wrap.head_c.pc", upd_pc, 32'h20);
    chk("wrap.head_c.target", upd_target, 32'h0);
    issue();
    upd_ready = 1'b0;
    chk("wrap.res_valid", {30'b0, res_valid}, 32'd2);
    chk("wrap.res_data1", res_data[1], 32'h48);
    chk("wrap.in_ready",  {31'b0, in_ready}, 32'd0);
    pop_chk("wrap.d", 32'h24, 32'h28, 1'b0);
    pop_chk("wrap.e", 32'h40, 32'h50, 1'b1);
    pop_chk("wrap.f", 32'h44, 32'h48, 1'b1);
    chk("wrap.empty", {31'b0, upd_valid}, 32'd0);

    // Reset with three queued entries and a redirect pending.
    set_lane(0, 4'd1, 32'h600, enc16(16'd4), 32'd1, 32'd2, 1'b0, 32'h0);
    set_lane(1, 4'd1, 32'h604, enc16(16'd4), 32'd1, 32'd2, 1'b0, 32'h0);
    issue();
    set_lane(0, 4'd8, 32'h500, enc26(26'd4), 32'd0, 32'd0, 1'b0, 32'h0);
    issue();
    chk("rst2.pre_redirect",    {31'b0, redirect}, 32'd1);
    chk("rst2.pre_redirect_pc", redirect_pc, 32'h510);
    chk("rst2.pre_res_data0",   res_data[0], 32'h504);
    rst_n = 1'b0;
    #1;
    chk("rst2.redirect",    {31'b0, redirect}, 32'd0);
    chk("rst2.redirect_pc", redirect_pc, 32'd0);
    chk("rst2.res_valid",   {30'b0, res_valid}, 32'd0);
    chk("rst2.res_data0",   res_data[0], 32'd0);
    chk("rst2.upd_valid",   {31'b0, upd_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2.in_ready",  {31'b0, in_ready}, 32'd1);
    chk("rst2.discarded", {31'b0, upd_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter CHANNELS, default 2, number of branch lanes resolved per cycle; lane 0 is oldest.
REQ-002 Parameter UQ_DEPTH, default 4, predictor-update queue entries; power of two, >= CHANNELS.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  in  CHANNELS  per-lane instruction valid.
REQ-006 Port in_ready  out  1  unit can accept this cycle's lanes.
REQ-007 Port pc, inst, reg1, reg2  in  CHANNELS x 32 each  lane PC, instruction word, source operands.
REQ-008 Port br_op  in  CHANNELS x 4  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 B, 8 BL, 9 JIRL, 10-15 treated as none.
REQ-009 Port pre_taken, pre_addr  in  CHANNELS x 1 / x 32  prediction carried with the lane.
REQ-010 Port flush_in  in  1  external backend flush (exception/ertn).
REQ-011 Port res_valid, res_data  out  CHANNELS x 1 / x 32  registered link-value writeback.
REQ-012 Port redirect, redirect_pc  out  1 / 32  registered front-end redirect.
REQ-013 Port upd_valid  out  1; upd_ready  in  1; upd_pc, upd_target  out  32 each; upd_taken  out  1  predictor-update stream, head of queue.

Function
REQ-014 Accept: lanes accepted on edge where in_ready=1, flush_in=0; in_ready = (free queue entries >= CHANNELS) and no redirect issued this cycle.
REQ-015 Offsets: 16-bit = sext(inst[25:10])<<2; 26-bit = sext({inst[9:0],inst[25:10]})<<2; all adds modulo 2^32.
REQ-016 Compares: BLT/BGE signed, BLTU/BGEU unsigned, full 32-bit; BEQ/BNE equality.
REQ-017 Target: B/BL and conditional branches = pc+offset; JIRL = reg1 + 16-bit offset; B/BL/JIRL always taken.
REQ-018 Actual next PC: taken -> target; not taken -> pc+4.
REQ-019 Mispredict per lane: taken != pre_taken, or both taken and pre_addr != target.
REQ-020 Only lowest-index valid mispredicting lane redirects; all higher lanes in that cycle squashed (no res_valid, no queue push).
REQ-021 Latency 1: redirect/redirect_pc/res_* registered on accept edge, high exactly one cycle; redirect_pc = winning lane's actual next PC.
REQ-022 res_valid[i]=1 with res_data=pc+4 for unsquashed BL/JIRL lanes; else res_valid[i]=0, res_data=0.
REQ-023 Queue push: every unsquashed lane with br_op 1-9 pushes {pc, actual next PC, taken}, in lane order, on accept edge.
REQ-024 Queue pop when upd_valid and upd_ready; upd_valid = not empty; push and pop same cycle permitted; pointers wrap modulo UQ_DEPTH.
REQ-025 Full: in_ready=0 until enough space; no push ever overwrites.
REQ-026 flush_in=1: no lanes accepted; next-cycle redirect and res_valid forced 0; queue contents retained and drain.
REQ-027 Cycle after redirect=1: in_ready=0 (wrong-path lanes dropped by frontend).

Reset
REQ-028 rst_n low asynchronously clears: queue pointers/count, redirect=0, redirect_pc=0, res_valid=0, res_data=0, upd_valid=0.
REQ-029 Reset mid-operation discards queued updates; in_ready=1 first cycle after release.

Verification
REQ-030 Lane0 BEQ pc=0x1C000000, reg1=reg2=5, offs16=+4 words, pre_taken=1 pre_addr=0x1C000010 -> no redirect, one push {0x1C000000,0x1C000010,1}.
REQ-031 Lane0 BLT reg1=0xFFFFFFFF reg2=1, pre_taken=0 -> redirect next cycle to target; lane1 BL in same cycle squashed, res_valid[1]=0.
REQ-032 Lane0 BNE not taken pre_taken=1 pc=0x100 -> redirect_pc=0x104, push taken=0; lane0 BLTU 0xFFFFFFFF<1 false likewise.
REQ-033 JIRL reg1=0x2000 offs=-1 word pc=0x300 -> target 0x1FFC, res_data=0x304.
REQ-034 upd_ready=0, push 4 branches (DEPTH 4) -> in_ready=0; upd_ready=1 one cycle with push -> order preserved, wrap correct.
REQ-035 rst_n low while queue holds 3 entries and redirect pending -> all outputs 0 immediately, upd_valid=0.
